// File: rtl/ddr_packet_reader.sv
// Reads a length-prefixed packet image back from DDR one 256-bit line at a time
// and streams it out LSB-word first as a sop/eop framed 32-bit word stream.
module ddr_packet_reader #(
    parameter int                ADDR_W    = 25,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(1),
    parameter int                MAX_WORDS = 256,
    parameter int                TIMEOUT   = 1023
) (
    input  logic              avalon_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cal_ok,
    output logic              rd_rq,
    output logic [ADDR_W-1:0] rd_adr,
    input  logic              rd_valid,
    input  logic [255:0]      rd_data,
    input  logic              action_done,
    output logic              wr_rq,
    output logic [ADDR_W-1:0] wr_adr,
    output logic [255:0]      wr_data,
    output logic [31:0]       byte_enable,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       pkt_len
);

    localparam int               TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [15:0]      MAX_LEN  = 16'(MAX_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        REQ_HDR,
        WAIT_HDR,
        CHECK,
        REQ_LINE,
        WAIT_LINE,
        STREAM,
        FINISH
    } state_t;

    state_t            state;
    logic [255:0]      line_buf;
    logic [ADDR_W-1:0] line_idx;
    logic [15:0]       words_left;
    logic [2:0]        word_sel;
    logic [TMR_W-1:0]  tmr;
    logic              seen_valid;
    logic              seen_done;

    logic              xact_done;
    logic [255:0]      line_next;
    logic [2:0]        sel_next;
    logic [ADDR_W-1:0] next_line_adr;

    // The write side of the DDR interface is never used by this reader.
    assign wr_rq       = 1'b0;
    assign wr_adr      = '0;
    assign wr_data     = '0;
    assign byte_enable = 32'hFFFF_FFFF;

    // rd_valid and action_done may land in the same cycle or in any order,
    // so completion merges the remembered flags with this cycle's strobes.
    always_comb begin
        xact_done     = (seen_valid | rd_valid) & (seen_done | action_done);
        line_next     = rd_valid ? rd_data : line_buf;
        sel_next      = word_sel + 3'd1;
        next_line_adr = BASE_ADDR + ADDR_W'(2) + line_idx;
    end

    always_ff @(posedge avalon_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            line_buf   <= '0;
            line_idx   <= '0;
            words_left <= '0;
            word_sel   <= '0;
            tmr        <= '0;
            seen_valid <= 1'b0;
            seen_done  <= 1'b0;
            rd_rq      <= 1'b0;
            rd_adr     <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            pkt_len    <= '0;
        end else begin
            rd_rq <= 1'b0;
            done  <= 1'b0;
            error <= 1'b0;

            case (state)
                IDLE: begin
                    if (start && cal_ok) begin
                        busy   <= 1'b1;
                        rd_rq  <= 1'b1;
                        rd_adr <= BASE_ADDR;
                        state  <= REQ_HDR;
                    end
                end

                REQ_HDR: begin
                    tmr        <= '0;
                    seen_valid <= 1'b0;
                    seen_done  <= 1'b0;
                    state      <= WAIT_HDR;
                end

                WAIT_HDR: begin
                    tmr <= tmr + TMR_W'(1);
                    if (rd_valid) begin
                        pkt_len    <= rd_data[15:0];
                        seen_valid <= 1'b1;
                    end
                    if (action_done) begin
                        seen_done <= 1'b1;
                    end
                    if (xact_done) begin
                        state <= CHECK;
                    end else if (tmr == TMR_LAST) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                CHECK: begin
                    if (pkt_len == 16'd0 || pkt_len > MAX_LEN) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        line_idx   <= '0;
                        words_left <= pkt_len;
                        rd_rq      <= 1'b1;
                        rd_adr     <= BASE_ADDR + ADDR_W'(1);
                        state      <= REQ_LINE;
                    end
                end

                REQ_LINE: begin
                    tmr        <= '0;
                    seen_valid <= 1'b0;
                    seen_done  <= 1'b0;
                    state      <= WAIT_LINE;
                end

                // First word comes from line_next so a same-cycle rd_valid is not lost.
                WAIT_LINE: begin
                    tmr <= tmr + TMR_W'(1);
                    if (rd_valid) begin
                        line_buf   <= rd_data;
                        seen_valid <= 1'b1;
                    end
                    if (action_done) begin
                        seen_done <= 1'b1;
                    end
                    if (xact_done) begin
                        word_sel  <= '0;
                        out_valid <= 1'b1;
                        out_data  <= line_next[31:0];
                        out_sop   <= (line_idx == '0);
                        out_eop   <= (words_left == 16'd1);
                        state     <= STREAM;
                    end else if (tmr == TMR_LAST) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                STREAM: begin
                    if (out_ready) begin
                        words_left <= words_left - 16'd1;
                        word_sel   <= sel_next;
                        if (words_left == 16'd1) begin
                            out_valid <= 1'b0;
                            out_sop   <= 1'b0;
                            out_eop   <= 1'b0;
                            done      <= 1'b1;
                            state     <= FINISH;
                        end else if (word_sel == 3'd7) begin
                            out_valid <= 1'b0;
                            out_sop   <= 1'b0;
                            out_eop   <= 1'b0;
                            line_idx  <= line_idx + ADDR_W'(1);
                            rd_rq     <= 1'b1;
                            rd_adr    <= next_line_adr;
                            state     <= REQ_LINE;
                        end else begin
                            out_data <= line_buf[32*sel_next +: 32];
                            out_sop  <= 1'b0;
                            out_eop  <= (words_left == 16'd2);
                        end
                    end
                end

                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_packet_reader.sv
// Bench for ddr_packet_reader: a DDR responder model plus a word scoreboard,
// driven from a vector table and a few hand-written corner sequences.
`timescale 1ns/1ps
module tb_ddr_packet_reader;

    localparam int ADDR_W  = 25;
    localparam int TIMEOUT = 1023;
    localparam int RD_LAT  = 2;

    logic              avalon_clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              cal_ok = 1'b1;
    logic              rd_rq;
    logic [ADDR_W-1:0] rd_adr;
    logic              rd_valid = 1'b0;
    logic [255:0]      rd_data = '0;
    logic              action_done = 1'b0;
    logic              wr_rq;
    logic [ADDR_W-1:0] wr_adr;
    logic [255:0]      wr_data;
    logic [31:0]       byte_enable;
    logic [31:0]       out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_sop;
    logic              out_eop;
    logic              busy;
    logic              done;
    logic              error;
    logic [15:0]       pkt_len;

    ddr_packet_reader #(
        .ADDR_W(ADDR_W), .BASE_ADDR(25'd1), .MAX_WORDS(256), .TIMEOUT(TIMEOUT)
    ) dut (
        .avalon_clk(avalon_clk), .rst_n(rst_n), .start(start), .cal_ok(cal_ok),
        .rd_rq(rd_rq), .rd_adr(rd_adr), .rd_valid(rd_valid), .rd_data(rd_data),
        .action_done(action_done), .wr_rq(wr_rq), .wr_adr(wr_adr), .wr_data(wr_data),
        .byte_enable(byte_enable), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop), .busy(busy),
        .done(done), .error(error), .pkt_len(pkt_len)
    );

    always #5 avalon_clk = ~avalon_clk;

    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eop;
    } word_t;

    typedef struct {
        int len;
        int ready_mode;
        int ack_delay;
        int seed;
        bit exp_err;
        int exp_lines;
    } vec_t;

    int                errors = 0;
    int                checks = 0;
    word_t             exp_q[$];
    logic [ADDR_W-1:0] exp_adr_q[$];
    logic [31:0]       payload [0:255];
    logic [15:0]       hdr_len = '0;
    int                ready_mode = 0;
    int                ack_delay = 0;
    bit                withhold = 0;
    bit                inject_late = 0;
    int                done_cnt = 0;
    int                error_cnt = 0;
    int                accepted_cnt = 0;
    int                valid_cnt = 0;
    longint            cycle = 0;
    longint            rq_cycle = 0;
    longint            err_cycle = 0;
    bit                pending = 0;
    int                wait_cnt = 0;
    logic [ADDR_W-1:0] req_adr = '0;
    bit                prev_stall = 0;
    logic [33:0]       prev_out = '0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] lineFor(input logic [ADDR_W-1:0] adr);
        logic [255:0] l;
        int a;
        int base;
        l = '0;
        a = int'(adr);
        if (a == 1) begin
            l = {8{32'hA5A5_0000}};
            l[15:0] = hdr_len;
        end else if (a >= 2 && a < 34) begin
            base = (a - 2) * 8;
            for (int i = 0; i < 8; i++) l[32*i +: 32] = payload[base + i];
        end
        return l;
    endfunction

    task automatic fillPayload(input int seed);
        for (int k = 0; k < 256; k++) begin
            payload[k] = {8'(seed), 8'(k), 16'(16'h5A00 + k * 7)};
        end
        if (seed == 0) begin
            payload[0]  = 32'h0000_0040;
            payload[1]  = 32'h0000_14CC;
            payload[13] = 32'h34CC_AB00;
        end
    endtask

    // DDR responder, stream sink and event counters share one process so
    // their per-cycle ordering is fixed.
    always @(negedge avalon_clk) begin
        word_t w;
        cycle++;
        rd_valid    = 1'b0;
        action_done = 1'b0;
        if (!rst_n) begin
            pending    = 0;
            prev_stall = 0;
        end else begin
            if (inject_late) begin
                rd_valid    = 1'b1;
                action_done = 1'b1;
                rd_data     = lineFor(req_adr);
                pending     = 0;
                inject_late = 0;
            end else if (rd_rq) begin
                checkOutput("single_outstanding", 64'(pending), 64'd0);
                if (exp_adr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_request: got adr 0x%0h, expected none", rd_adr);
                end else begin
                    checkOutput("rd_adr", 64'(rd_adr), 64'(exp_adr_q.pop_front()));
                end
                pending  = 1;
                wait_cnt = 0;
                req_adr  = rd_adr;
                rq_cycle = cycle;
            end else if (pending) begin
                checkOutput("rd_adr_stable", 64'(rd_adr), 64'(req_adr));
                wait_cnt++;
                if (!(withhold && int'(req_adr) != 1)) begin
                    if (wait_cnt == RD_LAT) begin
                        rd_valid = 1'b1;
                        rd_data  = lineFor(req_adr);
                    end
                    if (wait_cnt == RD_LAT + ack_delay) begin
                        action_done = 1'b1;
                        pending     = 0;
                    end
                end
            end

            if (prev_stall) begin
                checkOutput("stall_hold", {out_valid, out_sop, out_eop, out_data}, {1'b1, prev_out});
            end
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_word: got 0x%0h, expected no word", out_data);
                end else begin
                    w = exp_q.pop_front();
                    checkOutput($sformatf("word%0d", accepted_cnt),
                                {out_sop, out_eop, out_data}, {w.sop, w.eop, w.data});
                end
                accepted_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_sop, out_eop, out_data};
            if (out_valid) valid_cnt++;
            if (done) done_cnt++;
            if (error) begin
                error_cnt++;
                err_cycle = cycle;
            end
        end
    end

    task automatic applyStimulus(input int len, input int rmode, input int adelay,
                                 input int nlines, input bit push_words);
        word_t w;
        hdr_len    = 16'(len);
        ready_mode = rmode;
        ack_delay  = adelay;
        exp_adr_q.push_back(ADDR_W'(1));
        for (int i = 0; i < nlines; i++) exp_adr_q.push_back(ADDR_W'(2 + i));
        if (push_words) begin
            for (int k = 0; k < len; k++) begin
                w.data = payload[k];
                w.sop  = (k == 0);
                w.eop  = (k == len - 1);
                exp_q.push_back(w);
            end
        end
        done_cnt     = 0;
        error_cnt    = 0;
        valid_cnt    = 0;
        accepted_cnt = 0;
        @(negedge avalon_clk);
        start = 1'b1;
        @(negedge avalon_clk);
        start = 1'b0;
    endtask

    task automatic waitEnd(input string name);
        int n;
        n = 0;
        while (done_cnt == 0 && error_cnt == 0 && n < 5000) begin
            @(negedge avalon_clk);
            n++;
        end
        checkOutput({name, "_finished"}, 64'(n < 5000), 64'd1);
        repeat (2) @(negedge avalon_clk);
    endtask

    task automatic checkPacket(input string name, input int len, input bit exp_err);
        checkOutput({name, "_done"}, 64'(done_cnt), exp_err ? 64'd0 : 64'd1);
        checkOutput({name, "_error"}, 64'(error_cnt), 64'(exp_err));
        checkOutput({name, "_pkt_len"}, 64'(pkt_len), 64'(16'(len)));
        checkOutput({name, "_busy"}, 64'(busy), 64'd0);
        checkOutput({name, "_words_left"}, 64'(exp_q.size()), 64'd0);
        checkOutput({name, "_reqs_left"}, 64'(exp_adr_q.size()), 64'd0);
        if (exp_err) checkOutput({name, "_no_valid"}, 64'(valid_cnt), 64'd0);
        exp_q.delete();
        exp_adr_q.delete();
    endtask

    task automatic checkResetState(input string name);
        checkOutput({name, "_ctrl"}, {rd_rq, out_valid, out_sop, out_eop, busy, done, error, wr_rq}, 64'd0);
        checkOutput({name, "_rd_adr"}, 64'(rd_adr), 64'd0);
        checkOutput({name, "_out_data"}, 64'(out_data), 64'd0);
        checkOutput({name, "_pkt_len"}, 64'(pkt_len), 64'd0);
        checkOutput({name, "_wr"}, {63'd0, (|wr_data) | (|wr_adr)}, 64'd0);
        checkOutput({name, "_byte_enable"}, 64'(byte_enable), 64'hFFFF_FFFF);
    endtask

    initial begin
        vec_t vecs[8];
        int   n;
        vecs[0] = '{14,  0, 0, 0, 1'b0, 2};
        vecs[1] = '{8,   1, 0, 1, 1'b0, 1};
        vecs[2] = '{0,   0, 0, 2, 1'b1, 0};
        vecs[3] = '{257, 0, 0, 2, 1'b1, 0};
        vecs[4] = '{14,  0, 3, 0, 1'b0, 2};
        vecs[5] = '{256, 2, 1, 6, 1'b0, 32};
        vecs[6] = '{1,   0, 0, 7, 1'b0, 1};
        vecs[7] = '{9,   2, 2, 8, 1'b0, 2};

        #1;
        checkResetState("reset_init");
        repeat (2) @(negedge avalon_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge avalon_clk);

        for (int v = 0; v < 8; v++) begin
            fillPayload(vecs[v].seed);
            applyStimulus(vecs[v].len, vecs[v].ready_mode, vecs[v].ack_delay,
                          vecs[v].exp_lines, !vecs[v].exp_err);
            waitEnd($sformatf("vec%0d", v));
            checkPacket($sformatf("vec%0d", v), vecs[v].len, vecs[v].exp_err);
        end

        // start must be ignored without calibration
        cal_ok = 1'b0;
        @(negedge avalon_clk);
        start = 1'b1;
        @(negedge avalon_clk);
        start = 1'b0;
        repeat (5) @(negedge avalon_clk);
        checkOutput("no_cal_busy", 64'(busy), 64'd0);
        cal_ok = 1'b1;

        // line request never answered: abort after the timeout, ignore late data
        fillPayload(3);
        withhold = 1;
        applyStimulus(14, 0, 0, 1, 1'b0);
        n = 0;
        while (error_cnt == 0 && n < TIMEOUT + 100) begin
            @(negedge avalon_clk);
            n++;
        end
        checkOutput("timeout_error", 64'(error_cnt), 64'd1);
        checkOutput("timeout_latency",
                    64'((err_cycle - rq_cycle) >= TIMEOUT && (err_cycle - rq_cycle) <= TIMEOUT + 2), 64'd1);
        checkOutput("timeout_no_valid", 64'(valid_cnt), 64'd0);
        withhold = 0;
        @(negedge avalon_clk);
        inject_late = 1;
        repeat (5) @(negedge avalon_clk);
        checkOutput("late_data_busy", 64'(busy), 64'd0);
        checkOutput("late_data_no_valid", 64'(valid_cnt + done_cnt), 64'd0);
        checkPacket("timeout", 14, 1'b1);
        fillPayload(4);
        applyStimulus(14, 0, 0, 2, 1'b1);
        waitEnd("after_timeout");
        checkPacket("after_timeout", 14, 1'b0);

        // asynchronous reset in the middle of streaming
        fillPayload(0);
        applyStimulus(14, 0, 0, 2, 1'b1);
        n = 0;
        while (accepted_cnt < 5 && n < 200) begin
            @(negedge avalon_clk);
            n++;
        end
        checkOutput("reached_word5", 64'(accepted_cnt >= 5), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        checkResetState("reset_mid");
        exp_q.delete();
        exp_adr_q.delete();
        repeat (3) @(negedge avalon_clk);
        rst_n = 1'b1;
        repeat (3) @(negedge avalon_clk);
        checkOutput("no_done_after_reset", 64'(done_cnt), 64'd0);
        applyStimulus(14, 2, 1, 2, 1'b1);
        waitEnd("restart");
        checkPacket("restart", 14, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
